stopwatch_counter: RTL and testbench

- Time-keeping source for the four-digit 7-segment display path; the producer end of the BCD digit interface that the display driver consumes.
- Keeps an MM:SS BCD count with run/pause and a clear button, plus an adjust mode that steps minutes or seconds.
- Debounces the raw push-buttons internally.
- Outputs are the thousands/hundreds (minutes) and tens/units (seconds) digits, fed directly to the display driver alongside adj/sel.

---
 rtl/stopwatch_counter_pkg.sv | 36 +++
 rtl/stopwatch_counter_debounce_pulse.sv | 63 ++++++
 rtl/stopwatch_counter.sv | 102 ++++++++++
 tb/tb_stopwatch_counter.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/stopwatch_counter_pkg.sv
// rtl/stopwatch_counter_pkg.sv - BCD widths, digit limits and two-digit increment helpers
package stopwatch_counter_pkg;

    localparam int BCD_W        = 4;
    localparam int SEC_TENS_MAX = 5;
    localparam int DIGIT_MAX    = 9;
    localparam int MIN_MAX      = 99;

    typedef logic [BCD_W-1:0] bcd_t;

    typedef struct packed {
        bcd_t hi;
        bcd_t lo;
    } bcd_pair_t;

    // Saturating compares keep an out-of-range digit from ever counting past its limit.
    function automatic logic bcd_pair_at_max(input bcd_t hi, input bcd_t lo, input bcd_t hi_max);
        return (lo >= bcd_t'(DIGIT_MAX)) && (hi >= hi_max);
    endfunction

    function automatic bcd_pair_t bcd_pair_next(input bcd_t hi, input bcd_t lo, input bcd_t hi_max);
        bcd_pair_t r;
        r.hi = hi;
        r.lo = lo + bcd_t'(1);
        if (lo >= bcd_t'(DIGIT_MAX)) begin
            r.lo = '0;
            if (hi >= hi_max) begin
                r.hi = '0;
            end else begin
                r.hi = hi + bcd_t'(1);
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/stopwatch_counter_debounce_pulse.sv
// rtl/stopwatch_counter_debounce_pulse.sv - button synchronizer, debounce filter and press pulse
module debounce_pulse #(
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int SYNC_STAGES     = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic i_btn,
    output logic o_pulse
);

    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] r_sync;
    logic [SYNC_STAGES-1:0] r_fill;
    logic [CNT_W-1:0]       r_cnt;
    logic                   r_level;
    logic                   r_level_d;
    logic                   r_armed;
    logic                   w_synced;
    logic                   w_fill_done;

    assign w_synced    = r_sync[SYNC_STAGES-1];
    assign w_fill_done = r_fill[SYNC_STAGES-1];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync    <= '0;
            r_fill    <= '0;
            r_cnt     <= '0;
            r_level   <= 1'b0;
            r_level_d <= 1'b0;
            r_armed   <= 1'b0;
        end else begin
            r_sync[0] <= i_btn;
            r_fill[0] <= 1'b1;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                r_sync[i] <= r_sync[i-1];
                r_fill[i] <= r_fill[i-1];
            end

            if (w_synced == r_level) begin
                r_cnt <= '0;
            end else if (r_cnt == CNT_LAST) begin
                r_level <= w_synced;
                r_cnt   <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end

            r_level_d <= r_level;

            // A button held through reset must be seen released before its next press counts.
            if (w_fill_done && !w_synced && !r_level) begin
                r_armed <= 1'b1;
            end
        end
    end

    assign o_pulse = r_level & ~r_level_d & r_armed;

endmodule

// File: rtl/stopwatch_counter.sv
// rtl/stopwatch_counter.sv - MM:SS BCD stopwatch with run/pause, clear and minute/second adjust
module stopwatch_counter
    import stopwatch_counter_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int SYNC_STAGES     = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tick_1hz,
    input  logic             tick_2hz,
    input  logic             adj,
    input  logic             sel,
    input  logic             pause_btn,
    input  logic             reset_btn,
    output logic [BCD_W-1:0] units,
    output logic [BCD_W-1:0] tens,
    output logic [BCD_W-1:0] hundreds,
    output logic [BCD_W-1:0] thousands,
    output logic             running
);

    bcd_t      r_units;
    bcd_t      r_tens;
    bcd_t      r_hundreds;
    bcd_t      r_thousands;
    logic      r_running;

    logic      w_pause_p;
    logic      w_clr_p;
    bcd_pair_t w_sec_next;
    bcd_pair_t w_min_next;
    logic      w_sec_wrap;

    debounce_pulse #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .SYNC_STAGES    (SYNC_STAGES)
    ) u_pause_db (
        .clk    (clk),
        .rst    (rst),
        .i_btn  (pause_btn),
        .o_pulse(w_pause_p)
    );

    debounce_pulse #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .SYNC_STAGES    (SYNC_STAGES)
    ) u_clear_db (
        .clk    (clk),
        .rst    (rst),
        .i_btn  (reset_btn),
        .o_pulse(w_clr_p)
    );

    assign w_sec_next = bcd_pair_next(r_tens, r_units, bcd_t'(SEC_TENS_MAX));
    assign w_sec_wrap = bcd_pair_at_max(r_tens, r_units, bcd_t'(SEC_TENS_MAX));
    assign w_min_next = bcd_pair_next(r_thousands, r_hundreds, bcd_t'(MIN_MAX / 10));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_units     <= '0;
            r_tens      <= '0;
            r_hundreds  <= '0;
            r_thousands <= '0;
            r_running   <= 1'b1;
        end else begin
            if (w_pause_p) begin
                r_running <= ~r_running;
            end

            // Increment decisions use r_running as registered, before any toggle this cycle.
            if (w_clr_p) begin
                r_units     <= '0;
                r_tens      <= '0;
                r_hundreds  <= '0;
                r_thousands <= '0;
            end else if (!adj && tick_1hz && r_running) begin
                r_tens  <= w_sec_next.hi;
                r_units <= w_sec_next.lo;
                if (w_sec_wrap) begin
                    r_thousands <= w_min_next.hi;
                    r_hundreds  <= w_min_next.lo;
                end
            end else if (adj && tick_2hz) begin
                if (sel) begin
                    r_tens  <= w_sec_next.hi;
                    r_units <= w_sec_next.lo;
                end else begin
                    r_thousands <= w_min_next.hi;
                    r_hundreds  <= w_min_next.lo;
                end
            end
        end
    end

    assign units     = r_units;
    assign tens      = r_tens;
    assign hundreds  = r_hundreds;
    assign thousands = r_thousands;
    assign running   = r_running;

endmodule

// File: tb/tb_stopwatch_counter.sv
// tb/tb_stopwatch_counter.sv - directed vector bench for stopwatch_counter
module tb_stopwatch_counter;

    logic       clk = 1'b0;
    logic       rst;
    logic       tick_1hz;
    logic       tick_2hz;
    logic       adj;
    logic       sel;
    logic       pause_btn;
    logic       reset_btn;
    logic [3:0] units;
    logic [3:0] tens;
    logic [3:0] hundreds;
    logic [3:0] thousands;
    logic       running;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        logic        adj;
        logic        sel;
        int          n1;
        int          n2;
        logic [15:0] exp_digits;
        logic        exp_run;
    } vec_t;

    vec_t vecs[12];

    stopwatch_counter #(
        .DEBOUNCE_CYCLES(4),
        .SYNC_STAGES    (2)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .tick_1hz (tick_1hz),
        .tick_2hz (tick_2hz),
        .adj      (adj),
        .sel      (sel),
        .pause_btn(pause_btn),
        .reset_btn(reset_btn),
        .units    (units),
        .tens     (tens),
        .hundreds (hundreds),
        .thousands(thousands),
        .running  (running)
    );

    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] digits();
        return {thousands, hundreds, tens, units};
    endfunction

    task automatic pulse1(input int n);
        repeat (n) begin
            tick_1hz = 1'b1;
            step(1);
            tick_1hz = 1'b0;
            step(1);
        end
    endtask

    task automatic pulse2(input int n);
        repeat (n) begin
            tick_2hz = 1'b1;
            step(1);
            tick_2hz = 1'b0;
            step(1);
        end
    endtask

    initial begin
        vecs[0]  = '{1'b0, 1'b0, 60, 0,   16'h0100, 1'b1};
        vecs[1]  = '{1'b0, 1'b0, 59, 3,   16'h0159, 1'b1};
        vecs[2]  = '{1'b0, 1'b0, 1,  0,   16'h0200, 1'b1};
        vecs[3]  = '{1'b1, 1'b0, 3,  97,  16'h9900, 1'b1};
        vecs[4]  = '{1'b1, 1'b1, 0,  59,  16'h9959, 1'b1};
        vecs[5]  = '{1'b0, 1'b0, 1,  0,   16'h0000, 1'b1};
        vecs[6]  = '{1'b0, 1'b0, 58, 0,   16'h0058, 1'b1};
        vecs[7]  = '{1'b1, 1'b1, 5,  3,   16'h0001, 1'b1};
        vecs[8]  = '{1'b1, 1'b0, 2,  100, 16'h0001, 1'b1};
        vecs[9]  = '{1'b1, 1'b0, 0,  12,  16'h1201, 1'b1};
        vecs[10] = '{1'b1, 1'b1, 0,  33,  16'h1234, 1'b1};
        vecs[11] = '{1'b0, 1'b0, 0,  0,   16'h1234, 1'b1};

        rst       = 1'b1;
        tick_1hz  = 1'b0;
        tick_2hz  = 1'b0;
        adj       = 1'b0;
        sel       = 1'b0;
        pause_btn = 1'b0;
        reset_btn = 1'b0;
        step(2);
        check("reset_digits", {16'h0, digits()}, 32'h0000);
        check("reset_running", {31'h0, running}, 32'h1);
        rst = 1'b0;
        step(10);
        check("release_digits", {16'h0, digits()}, 32'h0000);
        check("release_running", {31'h0, running}, 32'h1);

        for (int i = 0; i < 12; i++) begin
            adj = vecs[i].adj;
            sel = vecs[i].sel;
            pulse1(vecs[i].n1);
            pulse2(vecs[i].n2);
            check($sformatf("vec%0d_digits", i), {16'h0, digits()}, {16'h0, vecs[i].exp_digits});
            check($sformatf("vec%0d_running", i), {31'h0, running}, {31'h0, vecs[i].exp_run});
        end

        // Clear pulse lands on the 7th edge after the press, together with a 1 Hz tick.
        reset_btn = 1'b1;
        step(6);
        tick_1hz = 1'b1;
        step(1);
        tick_1hz = 1'b0;
        check("clr_tick_digits", {16'h0, digits()}, 32'h0000);
        check("clr_tick_running", {31'h0, running}, 32'h1);
        step(10);
        pulse1(1);
        check("clr_held_once", {16'h0, digits()}, 32'h0001);
        reset_btn = 1'b0;
        step(10);

        pause_btn = 1'b1;
        step(6);
        tick_1hz = 1'b1;
        step(1);
        tick_1hz = 1'b0;
        check("pause_tick_digits", {16'h0, digits()}, 32'h0002);
        check("pause_tick_running", {31'h0, running}, 32'h0);
        step(10);
        check("pause_held_once", {31'h0, running}, 32'h0);
        pause_btn = 1'b0;
        step(10);
        pulse1(5);
        check("paused_no_count", {16'h0, digits()}, 32'h0002);
        pause_btn = 1'b1;
        step(12);
        check("resume_running", {31'h0, running}, 32'h1);
        pause_btn = 1'b0;
        step(10);
        pulse1(1);
        check("resume_count", {16'h0, digits()}, 32'h0003);

        pause_btn = 1'b1;
        step(3);
        pause_btn = 1'b0;
        step(12);
        check("glitch_reject", {31'h0, running}, 32'h1);
        pause_btn = 1'b1;
        step(1);
        pause_btn = 1'b0;
        step(1);
        pause_btn = 1'b1;
        step(15);
        check("bounce_one_pulse", {31'h0, running}, 32'h0);
        pause_btn = 1'b0;
        step(10);
        pause_btn = 1'b1;
        step(12);
        check("bounce_restore", {31'h0, running}, 32'h1);
        pause_btn = 1'b0;
        step(10);

        rst = 1'b1;
        step(1);
        rst = 1'b0;
        adj = 1'b1;
        sel = 1'b0;
        pulse2(45);
        sel = 1'b1;
        pulse2(17);
        adj = 1'b0;
        check("preload_4517", {16'h0, digits()}, 32'h4517);
        pause_btn = 1'b1;
        step(3);
        rst = 1'b1;
        step(1);
        check("midrst_digits", {16'h0, digits()}, 32'h0000);
        check("midrst_running", {31'h0, running}, 32'h1);
        rst = 1'b0;
        step(20);
        check("held_through_rst", {31'h0, running}, 32'h1);
        pause_btn = 1'b0;
        step(12);
        check("release_after_rst", {31'h0, running}, 32'h1);
        pause_btn = 1'b1;
        step(12);
        check("repress_after_rst", {31'h0, running}, 32'h0);
        pause_btn = 1'b0;
        step(10);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
